fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's word address; the memory read is combinational.
- Captures the returned instruction plus PC+4 into the IF/ID pipeline register consumed by decode.
- Handles decode stalls, branch/jump redirects with wrong-path squash, and a sticky address-fault halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 128, instruction memory depth in words; legal byte addresses are 0 .. IMEM_WORDS*4-4
NOP_INSTR, 32'h0000_0000, bubble instruction inserted on squash or fault

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  reset, asynchronous, active-low
Stall  in  1  decode cannot accept; hold PC and IF/ID
Redirect  in  1  taken branch/jump resolved in decode
RedirectTarget  in  32  byte address of next fetch when Redirect=1
ImemAddress  out  32  address to instruction memory (= PC)
ImemInstruction  in  32  instruction returned by memory, same cycle
PC  out  32  current fetch PC
IfId_Instruction  out  32  registered instruction to decode
IfId_PCPlus4  out  32  registered PC+4 of that instruction
IfId_Valid  out  1  1 = IF/ID holds a real instruction
AddrFault  out  1  sticky fault flag

Behaviour:
- Reset (Rst=0, asynchronous, immediate) sets:
  - PC=RESET_PC
  - IfId_Instruction=NOP_INSTR
  - IfId_PCPlus4=0
  - IfId_Valid=0
  - AddrFault=0
  - state=BOOT
- ImemAddress = PC, combinational.
- FSM states: BOOT, RUN, FAULT.
- BOOT (one cycle after reset release):
  - IF/ID stays bubble; PC holds.
  - -> RUN unconditionally. Stall and Redirect are ignored.
- RUN: per-edge priority is Redirect > Stall > advance.
  - Redirect=1, target legal:
    - PC<=RedirectTarget.
    - IF/ID <= {NOP_INSTR, 0, Valid=0}, squashing the wrong-path fetch.
    - Applies even when Stall=1.
  - Redirect=1, target illegal (RedirectTarget[1:0]!=0, or RedirectTarget[31:2] >= IMEM_WORDS):
    - PC holds; IF/ID <= bubble; AddrFault<=1; -> FAULT.
  - Stall=1, Redirect=0: PC, IfId_* and IfId_Valid all hold their values.
  - Otherwise (advance):
    - IfId_Instruction<=ImemInstruction.
    - IfId_PCPlus4<=PC+4; IfId_Valid<=1.
    - PC<=next sequential PC.
- Sequential PC arithmetic:
  - 32-bit add of 4.
  - If PC+4 == IMEM_WORDS*4, next PC wraps to 0. This is not a fault.
  - IfId_PCPlus4 still records the unwrapped PC+4 (0x200 for the last word at default depth).
- FAULT:
  - Terminal until reset; IF/ID bubble every cycle.
  - PC frozen; Stall and Redirect ignored; AddrFault stays 1.
- Latency: instruction at PC appears on IfId_Instruction one edge after PC is presented (zero stalls).
- Simultaneous reset with any input: reset wins.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, RUN, FAULT}
  - NOP constant
  - PC_STEP=4
  - IF/ID bundle struct {instruction, pc_plus4, valid}, reused by the decode stage.
- One natural sub-module: if_id_register.
  - Holds the bundle; has load, hold and bubble controls, with async active-low reset to the bubble value.
  - Fetch FSM and PC logic stay in fetch_stage.

Test Plan:
1. Release Rst, Stall=0, Redirect=0, mem[i]=i*4 -> edge 1 (BOOT): Valid=0, PC=0. Edge 2: IfId_Instruction=0x0, IfId_PCPlus4=0x4, PC=0x4. Edge 3: Instruction=0x4, PCPlus4=0x8.
2. At PC=0x8 hold Stall=1 for 3 edges -> PC stays 0x8 and IF/ID unchanged. First edge after release captures mem[2]=0x8, PCPlus4=0xC.
3. Redirect=1, RedirectTarget=0x40 with Stall=1 at the same edge -> PC=0x40, IfId_Valid=0, IfId_Instruction=0x0. Next edge: IfId_Instruction=mem[16], PCPlus4=0x44.
4. Advance through PC=0x1FC -> IfId_Instruction=mem[127], IfId_PCPlus4=0x200, PC wraps to 0x0. Next capture is mem[0].
5. Redirect to 0x42 -> AddrFault=1, PC holds, Valid=0 permanently; later Redirect to 0x40 is ignored. Separate run with Redirect to 0x200 -> same fault. Pulling Rst low clears AddrFault.
6. Assert Rst mid-stall between clock edges -> all outputs take reset values immediately, before the next edge. On release, sequencing restarts from BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode types, FSM states and constants
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // A fetch address is legal when word aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID signal bundle
interface fetch_stage_if;

  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] PC;
  logic [31:0] IfId_Instruction;
  logic [31:0] IfId_PCPlus4;
  logic        IfId_Valid;
  logic        AddrFault;

  modport master (
    input  Stall, Redirect, RedirectTarget, ImemInstruction,
    output ImemAddress, PC, IfId_Instruction, IfId_PCPlus4, IfId_Valid, AddrFault
  );

  modport slave (
    output Stall, Redirect, RedirectTarget, ImemInstruction,
    input  ImemAddress, PC, IfId_Instruction, IfId_PCPlus4, IfId_Valid, AddrFault
  );

endinterface

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t data_i,
  output if_id_t data_o
);

  localparam if_id_t BUBBLE = '{instruction: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  if_id_t bundle_q;
  if_id_t bundle_d;

  // Bubble outranks load so a squash always wins; neither asserted means hold.
  always_comb begin
    bundle_d = bundle_q;
    if (bubble_i) begin
      bundle_d = BUBBLE;
    end else if (load_i) begin
      bundle_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bundle_q <= BUBBLE;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign data_o = bundle_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, fetch FSM and IF/ID capture ahead of decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input logic          Clk,
  input logic          Rst,
  fetch_stage_if.master bus
);

  localparam logic [31:0] WORDS      = 32'(IMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  pc_seq;
  logic         target_legal;
  logic         ifid_load;
  logic         ifid_bubble;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  // The recorded PC+4 stays unwrapped; only the next fetch address wraps.
  assign pc_plus4     = pc_q + PC_STEP;
  assign pc_seq       = (pc_plus4 == IMEM_BYTES) ? 32'h0 : pc_plus4;
  assign target_legal = addr_legal(bus.RedirectTarget, WORDS);

  assign ifid_d = '{instruction: bus.ImemInstruction, pc_plus4: pc_plus4, valid: 1'b1};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (bus.Redirect) begin
          ifid_bubble = 1'b1;
          if (target_legal) begin
            pc_d = bus.RedirectTarget;
          end else begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end else if (!bus.Stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_seq;
        end
      end
      ST_FAULT: begin
        ifid_bubble = 1'b1;
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i    (Clk),
    .rst_ni   (Rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .data_i   (ifid_d),
    .data_o   (ifid_q)
  );

  assign bus.ImemAddress      = pc_q;
  assign bus.PC               = pc_q;
  assign bus.AddrFault        = fault_q;
  assign bus.IfId_Instruction = ifid_q.instruction;
  assign bus.IfId_PCPlus4     = ifid_q.pc_plus4;
  assign bus.IfId_Valid       = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] mem [0:127];

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (128),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ImemInstruction = mem[bus.ImemAddress[8:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectTarget = 32'h0;
    step();
    step();
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 32'h0); end
    checks++; if (bus.ImemAddress !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected %h", bus.ImemAddress, 32'h0); end
    checks++; if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.IfId_Valid); end
    checks++; if (bus.IfId_Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.IfId_Instruction, 32'h0); end
    checks++; if (bus.IfId_PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4: got %h expected %h", bus.IfId_PCPlus4, 32'h0); end
    checks++; if (bus.AddrFault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.AddrFault); end
  endtask

  task automatic test_boot_and_advance();
    rst_n = 1'b1;
    step();
    checks++; if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", bus.IfId_Valid); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h expected %h", bus.PC, 32'h0); end
    step();
    checks++; if (bus.IfId_Instruction !== 32'h0) begin errors++; $display("FAIL adv1_instr: got %h expected %h", bus.IfId_Instruction, 32'h0); end
    checks++; if (bus.IfId_PCPlus4 !== 32'h4) begin errors++; $display("FAIL adv1_pcplus4: got %h expected %h", bus.IfId_PCPlus4, 32'h4); end
    checks++; if (bus.IfId_Valid !== 1'b1) begin errors++; $display("FAIL adv1_valid: got %b expected 1", bus.IfId_Valid); end
    checks++; if (bus.PC !== 32'h4) begin errors++; $display("FAIL adv1_pc: got %h expected %h", bus.PC, 32'h4); end
    step();
    checks++; if (bus.IfId_Instruction !== 32'h4) begin errors++; $display("FAIL adv2_instr: got %h expected %h", bus.IfId_Instruction, 32'h4); end
    checks++; if (bus.IfId_PCPlus4 !== 32'h8) begin errors++; $display("FAIL adv2_pcplus4: got %h expected %h", bus.IfId_PCPlus4, 32'h8); end
    checks++; if (bus.PC !== 32'h8) begin errors++; $display("FAIL adv2_pc: got %h expected %h", bus.PC, 32'h8); end
  endtask

  task automatic test_stall();
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.PC !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, bus.PC, 32'h8); end
      checks++; if (bus.IfId_Instruction !== 32'h4 || bus.IfId_PCPlus4 !== 32'h8 || bus.IfId_Valid !== 1'b1) begin
        errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b expected %h/%h/1", i, bus.IfId_Instruction, bus.IfId_PCPlus4, bus.IfId_Valid, 32'h4, 32'h8);
      end
    end
    bus.Stall = 1'b0;
    step();
    checks++; if (bus.IfId_Instruction !== 32'h8) begin errors++; $display("FAIL unstall_instr: got %h expected %h", bus.IfId_Instruction, 32'h8); end
    checks++; if (bus.IfId_PCPlus4 !== 32'hC) begin errors++; $display("FAIL unstall_pcplus4: got %h expected %h", bus.IfId_PCPlus4, 32'hC); end
    checks++; if (bus.PC !== 32'hC) begin errors++; $display("FAIL unstall_pc: got %h expected %h", bus.PC, 32'hC); end
  endtask

  task automatic test_redirect();
    bus.Stall = 1'b1;
    bus.Redirect = 1'b1;
    bus.RedirectTarget = 32'h40;
    step();
    checks++; if (bus.PC !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h expected %h", bus.PC, 32'h40); end
    checks++; if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", bus.IfId_Valid); end
    checks++; if (bus.IfId_Instruction !== 32'h0) begin errors++; $display("FAIL redir_instr: got %h expected %h", bus.IfId_Instruction, 32'h0); end
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    step();
    checks++; if (bus.IfId_Instruction !== 32'h40) begin errors++; $display("FAIL redir_next_instr: got %h expected %h", bus.IfId_Instruction, 32'h40); end
    checks++; if (bus.IfId_PCPlus4 !== 32'h44) begin errors++; $display("FAIL redir_next_pcplus4: got %h expected %h", bus.IfId_PCPlus4, 32'h44); end
    checks++; if (bus.AddrFault !== 1'b0) begin errors++; $display("FAIL redir_no_fault: got %b expected 0", bus.AddrFault); end
  endtask

  task automatic test_wrap();
    int budget;
    budget = 0;
    while (bus.PC !== 32'h1FC && budget < 200) begin
      step();
      budget++;
    end
    checks++; if (bus.PC !== 32'h1FC) begin errors++; $display("FAIL wrap_reach: got %h expected %h", bus.PC, 32'h1FC); end
    step();
    checks++; if (bus.IfId_Instruction !== 32'h1FC) begin errors++; $display("FAIL wrap_instr: got %h expected %h", bus.IfId_Instruction, 32'h1FC); end
    checks++; if (bus.IfId_PCPlus4 !== 32'h200) begin errors++; $display("FAIL wrap_pcplus4: got %h expected %h", bus.IfId_PCPlus4, 32'h200); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", bus.PC, 32'h0); end
    checks++; if (bus.AddrFault !== 1'b0) begin errors++; $display("FAIL wrap_no_fault: got %b expected 0", bus.AddrFault); end
    step();
    checks++; if (bus.IfId_Instruction !== 32'h0 || bus.IfId_PCPlus4 !== 32'h4) begin
      errors++; $display("FAIL wrap_after: got %h/%h expected %h/%h", bus.IfId_Instruction, bus.IfId_PCPlus4, 32'h0, 32'h4);
    end
  endtask

  task automatic test_fault_misaligned();
    bus.Redirect = 1'b1;
    bus.RedirectTarget = 32'h42;
    step();
    checks++; if (bus.AddrFault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b expected 1", bus.AddrFault); end
    checks++; if (bus.PC !== 32'h4) begin errors++; $display("FAIL mis_pc: got %h expected %h", bus.PC, 32'h4); end
    checks++; if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", bus.IfId_Valid); end
    bus.RedirectTarget = 32'h40;
    step();
    step();
    checks++; if (bus.PC !== 32'h4) begin errors++; $display("FAIL mis_ignore_redir: got %h expected %h", bus.PC, 32'h4); end
    bus.Redirect = 1'b0;
    step();
    checks++; if (bus.PC !== 32'h4 || bus.IfId_Valid !== 1'b0 || bus.AddrFault !== 1'b1) begin
      errors++; $display("FAIL mis_frozen: got pc=%h valid=%b fault=%b expected pc=%h valid=0 fault=1", bus.PC, bus.IfId_Valid, bus.AddrFault, 32'h4);
    end
  endtask

  task automatic test_fault_range();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.AddrFault !== 1'b0) begin errors++; $display("FAIL range_reset_clears: got %b expected 0", bus.AddrFault); end
    bus.Redirect = 1'b1;
    bus.RedirectTarget = 32'h80;
    rst_n = 1'b1;
    step();
    checks++; if (bus.PC !== 32'h0 || bus.IfId_Valid !== 1'b0) begin
      errors++; $display("FAIL boot_ignores_redir: got pc=%h valid=%b expected pc=%h valid=0", bus.PC, bus.IfId_Valid, 32'h0);
    end
    bus.Redirect = 1'b0;
    step();
    bus.Redirect = 1'b1;
    bus.RedirectTarget = 32'h200;
    step();
    checks++; if (bus.AddrFault !== 1'b1) begin errors++; $display("FAIL range_fault: got %b expected 1", bus.AddrFault); end
    checks++; if (bus.PC !== 32'h4) begin errors++; $display("FAIL range_pc: got %h expected %h", bus.PC, 32'h4); end
    bus.Redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    step();
    step();
    bus.Stall = 1'b1;
    step();
    checks++; if (bus.PC !== 32'h8 || bus.IfId_Valid !== 1'b1) begin
      errors++; $display("FAIL pre_async_state: got pc=%h valid=%b expected pc=%h valid=1", bus.PC, bus.IfId_Valid, 32'h8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.PC !== 32'h0 || bus.ImemAddress !== 32'h0) begin errors++; $display("FAIL async_pc: got %h expected %h", bus.PC, 32'h0); end
    checks++; if (bus.IfId_Valid !== 1'b0 || bus.IfId_Instruction !== 32'h0 || bus.IfId_PCPlus4 !== 32'h0) begin
      errors++; $display("FAIL async_ifid: got %h/%h/%b expected 0/0/0", bus.IfId_Instruction, bus.IfId_PCPlus4, bus.IfId_Valid);
    end
    bus.Stall = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (bus.PC !== 32'h0 || bus.IfId_Valid !== 1'b0) begin
      errors++; $display("FAIL async_boot: got pc=%h valid=%b expected pc=%h valid=0", bus.PC, bus.IfId_Valid, 32'h0);
    end
    step();
    checks++; if (bus.PC !== 32'h4 || bus.IfId_PCPlus4 !== 32'h4 || bus.IfId_Valid !== 1'b1) begin
      errors++; $display("FAIL async_restart: got pc=%h pcplus4=%h valid=%b expected %h/%h/1", bus.PC, bus.IfId_PCPlus4, bus.IfId_Valid, 32'h4, 32'h4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
    test_reset();
    test_boot_and_advance();
    test_stall();
    test_redirect();
    test_wrap();
    test_fault_misaligned();
    test_fault_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
